// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the four-digit seven-segment scanner.
// Glyphs are active-low, bit 0 = segment a ... bit 6 = segment g.
package seven_seg_pkg;

  localparam int NUM_DIGITS = 4;

  // Digit index: 0 = ones ... 3 = thousands.
  typedef logic [1:0] digit_idx_t;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder.
// Codes above 9 render as a dash (segment g only).
module bcd_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Glyph lookup; every code maps to a value, so no storage is implied.
  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Snapshots the BCD digits on load, scans one digit per slot with a blanked
// guard interval, supports per-digit blink, a fixed decimal point and dashes
// for invalid codes. Optional leading-zero blanking: SEVEN_SEG_SCAN_LZB_EN.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int GUARD        = 4,
  parameter int BLINK_FRAMES = 125,
  parameter int DP_DIGIT     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            thos,
  input  logic [3:0]            huns,
  input  logic [3:0]            tens,
  input  logic [3:0]            ones,
  input  logic                  load,
  input  logic                  dp_en,
  input  logic [NUM_DIGITS-1:0] blink_mask,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SLOT_GUARD = SW'(GUARD);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam digit_idx_t    IDX_LAST   = digit_idx_t'(NUM_DIGITS - 1);
  localparam digit_idx_t    IDX_DP     = digit_idx_t'(DP_DIGIT);

  logic [15:0]           snap;
  logic [SW-1:0]         slot_cnt;
  digit_idx_t            idx;
  logic [FW-1:0]         frame_cnt;
  logic                  blink_phase;

  logic [3:0]            cur_bcd;
  logic [6:0]            cur_seg;
  logic                  lz_blank;
  logic                  lit;
  logic [NUM_DIGITS-1:0] an_next;
  logic [6:0]            seg_next;
  logic                  dp_next;

  // Snapshot register: the scan only ever reads this copy of the digits.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    snap <= '0;
    else if (load) snap <= {thos, huns, tens, ones};
  end

  // Slot, digit-index, frame and blink-phase counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt    <= '0;
      idx         <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (slot_cnt == SLOT_LAST) begin
      slot_cnt <= '0;
      idx      <= idx + 2'd1;
      if (idx == IDX_LAST) begin
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // Select the snapshot digit for the current slot and its blanking status.
  // NOTE: every always_comb output gets a default first so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    cur_bcd  = snap[3:0];
    lz_blank = 1'b0;
    case (idx)
      2'd1:    cur_bcd = snap[7:4];
      2'd2:    cur_bcd = snap[11:8];
      2'd3:    cur_bcd = snap[15:12];
      default: cur_bcd = snap[3:0];
    endcase
`ifdef SEVEN_SEG_SCAN_LZB_EN
    case (idx)
      2'd3:    lz_blank = (snap[15:12] == 4'd0);
      2'd2:    lz_blank = (snap[15:8]  == 8'd0);
      2'd1:    lz_blank = (snap[15:4]  == 12'd0);
      default: lz_blank = 1'b0;
    endcase
`else
    lz_blank = 1'b0;
`endif
  end

  bcd_to_seg u_dec (
    .bcd (cur_bcd),
    .seg (cur_seg)
  );

  // Next output values: dark during guard, blink-off phase or blanked zero.
  always_comb begin
    lit      = (slot_cnt >= SLOT_GUARD)
               && !(blink_mask[idx] && blink_phase)
               && !lz_blank;
    an_next  = '1;
    seg_next = SEG_OFF;
    dp_next  = 1'b1;
    if (lit) begin
      an_next     = '1;
      an_next[idx] = 1'b0;
      seg_next    = cur_seg;
      dp_next     = !(dp_en && (idx == IDX_DP));
    end
  end

  // Registered outputs, blanked immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= '1;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan (SCAN_DIV=8, GUARD=2,
// BLINK_FRAMES=2, DP_DIGIT=2). Honours SEVEN_SEG_SCAN_LZB_EN when defined.
module tb_seven_seg_scan;

  localparam int SCAN_DIV     = 8;
  localparam int GUARD        = 2;
  localparam int BLINK_FRAMES = 2;
  localparam int DP_DIGIT     = 2;
  localparam int FRAME        = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] thos = '0, huns = '0, tens = '0, ones = '0;
  logic       load = 1'b0;
  logic       dp_en = 1'b0;
  logic [3:0] blink_mask = '0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  seven_seg_scan #(
    .SCAN_DIV     (SCAN_DIV),
    .GUARD        (GUARD),
    .BLINK_FRAMES (BLINK_FRAMES),
    .DP_DIGIT     (DP_DIGIT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .thos       (thos),
    .huns       (huns),
    .tens       (tens),
    .ones       (ones),
    .load       (load),
    .dp_en      (dp_en),
    .blink_mask (blink_mask),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int k        = 0;  // rising edges since the last reset release

  typedef struct {
    logic [15:0]     digits;  // {thos, huns, tens, ones}
    logic            dp_en;
    logic [3:0]      lit;     // which slots light up
    logic [3:0][6:0] seg;     // expected glyph per slot, [3]=thousands
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s k=%0d: got %h expected %h", name, k, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    k++;
    @(negedge clk);
  endtask

  task automatic load_digits(input logic [15:0] d);
    {thos, huns, tens, ones} = d;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
  endtask

  // Check one whole frame, starting at a frame boundary, against a vector.
  task automatic run_frame(input vec_t v);
    int c, s;
    logic on;
    while (k % FRAME != 0) tick();
    for (int i = 0; i < FRAME; i++) begin
      tick();
      c  = (k - 1) % SCAN_DIV;
      s  = ((k - 1) / SCAN_DIV) % 4;
      on = (c >= GUARD) && v.lit[s];
      check("an",  {12'd0, an},  {12'd0, on ? ~(4'b0001 << s) : 4'b1111});
      check("seg", {9'd0, seg},  {9'd0, on ? v.seg[s] : 7'h7F});
      check("dp",  {15'd0, dp},  {15'd0, !(on && s == DP_DIGIT && v.dp_en)});
    end
  endtask

  initial begin
    tbl[0] = '{digits: 16'h1234, dp_en: 1'b0, lit: 4'b1111,
               seg: {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
    tbl[1] = '{digits: 16'h123C, dp_en: 1'b0, lit: 4'b1111,
               seg: {7'b1111001, 7'b0100100, 7'b0110000, 7'b0111111}};
`ifdef SEVEN_SEG_SCAN_LZB_EN
    tbl[2] = '{digits: 16'h0075, dp_en: 1'b0, lit: 4'b0011,
               seg: {7'b1000000, 7'b1000000, 7'b1111000, 7'b0010010}};
`else
    tbl[2] = '{digits: 16'h0075, dp_en: 1'b0, lit: 4'b1111,
               seg: {7'b1000000, 7'b1000000, 7'b1111000, 7'b0010010}};
`endif
    tbl[3] = '{digits: 16'h9860, dp_en: 1'b1, lit: 4'b1111,
               seg: {7'b0010000, 7'b0000000, 7'b0000010, 7'b1000000}};
    tbl[4] = '{digits: 16'hAFEB, dp_en: 1'b1, lit: 4'b1111,
               seg: {7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111}};

    // Reset state while held.
    repeat (3) @(negedge clk);
    check("rst_an",  {12'd0, an}, 16'h000F);
    check("rst_seg", {9'd0, seg}, 16'h007F);
    check("rst_dp",  {15'd0, dp}, 16'h0001);

    // First lit cycle is GUARD+1 after release, on digit 0.
    release_reset();
    tick();
    tick();
    check("guard_an", {12'd0, an}, 16'h000F);
    tick();
    check("first_lit_an",  {12'd0, an}, 16'h000E);
    check("first_lit_seg", {9'd0, seg}, 16'h0040);

    // Table-driven frames.
    for (int i = 0; i < 5; i++) begin
      dp_en = tbl[i].dp_en;
      load_digits(tbl[i].digits);
      run_frame(tbl[i]);
    end

    // Load during a lit slot: old glyph one more cycle, new glyph after.
    while ((k - 1) % FRAME != 3) tick();
    load_digits(16'hAFE6);
    check("load_lat1_seg", {9'd0, seg}, 16'h003F);
    tick();
    check("load_lat2_seg", {9'd0, seg}, 16'h0002);
    check("load_lat2_an",  {12'd0, an}, 16'h000E);

    // Asynchronous reset in the middle of a lit slot blanks at once.
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_an",  {12'd0, an}, 16'h000F);
    check("async_rst_seg", {9'd0, seg}, 16'h007F);
    check("async_rst_dp",  {15'd0, dp}, 16'h0001);
    dp_en = 1'b0;
    repeat (2) @(negedge clk);

    // Blink on digit 0: dark in frames 2-3, lit in 0-1 and 4.
    blink_mask = 4'b0001;
    release_reset();
    load_digits(16'h1234);
    while (k < 5 * FRAME) begin
      int c, s, f;
      logic on;
      tick();
      c  = (k - 1) % SCAN_DIV;
      s  = ((k - 1) / SCAN_DIV) % 4;
      f  = (k - 1) / FRAME;
      on = (c >= GUARD) && !(s == 0 && ((f / BLINK_FRAMES) % 2 == 1));
      check("blink_an", {12'd0, an}, {12'd0, on ? ~(4'b0001 << s) : 4'b1111});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Time-multiplexed driver for a 4-digit common-anode seven-segment display in the digital clock. It sits directly downstream of the binary-to-BCD converter and consumes its four BCD digits (thousands, hundreds, tens, ones). It snapshots them on a load strobe, then scans one digit at a time with a guard interval against ghosting. It also provides per-digit blinking, a fixed decimal-point position and dash display for invalid BCD codes.

## Interface
Parameters:
- SCAN_DIV, 100000: clock cycles per digit slot; must be ≥ GUARD+2.
- GUARD, 4: cycles at the start of each slot with all anodes off; must be ≥ 1.
- BLINK_FRAMES, 125: completed 4-digit frames per blink half-period; must be ≥ 1.
- DP_DIGIT, 2: digit index whose decimal point is lit when dp_en=1 (0=ones … 3=thousands).

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- thos, huns, tens, ones  in  4 each  BCD digits from the converter.
- load  in  1  single-cycle strobe; capture the four digits.
- dp_en  in  1  enable the decimal point on DP_DIGIT.
- blink_mask  in  4  bit i=1 makes digit i blink.
- an  out  4  anode enables, active-low; an[i] drives digit i.
- seg  out  7  cathodes, active-low; seg[0]=a … seg[6]=g.
- dp  out  1  decimal-point cathode, active-low.

## Operation
- Snapshot register, 16 bits. It captures {thos,huns,tens,ones} on any cycle with load=1. When load=0 it holds its value. The scan reads only the snapshot.
- Slot counter runs 0..SCAN_DIV-1 and wraps. On each wrap, the digit index advances 0→1→2→3→0.
- When the index wraps from 3 to 0, the frame counter increments. When the frame counter reaches BLINK_FRAMES-1 and then wraps, blink_phase toggles and the frame counter clears.
- Slot counter < GUARD: an=4'b1111, seg=7'h7F, dp=1.
- Slot counter ≥ GUARD: an drives a single 0 at the bit for the current digit index. seg shows the decoded snapshot digit for that index.
- Decode: codes 0–9 use the standard glyphs; for example 0=7'b1000000 and 8=7'b0000000. Codes 10–15 show a dash, seg=7'b0111111, which lights g only.
- Blink: if blink_mask[idx]=1 and blink_phase=1, an stays all-ones for that whole slot. The counters keep running.
- dp=0 only while digit DP_DIGIT is lit and dp_en=1. Otherwise dp=1.
- blink_mask and dp_en are sampled live every cycle and are not snapshotted.

## Timing
- Reset state: an=4'b1111, seg=7'h7F, dp=1. Slot counter, digit index, frame counter, blink_phase and snapshot are all 0.
- All outputs are registered and have no combinational path from any input.
- Output latency is one cycle from the counter state. The first lit cycle after reset is cycle GUARD+1 after rst_n deasserts, on digit 0.
- A load captured in cycle n is visible on seg from the next lit cycle of any slot, at the earliest cycle n+2. It never changes seg in the middle of a lit slot unless load occurs during that slot. This is accepted behaviour.
- Digit refresh rate is clk/(4·SCAN_DIV). The blink half-period is 4·SCAN_DIV·BLINK_FRAMES cycles.
- If load arrives on the same cycle as a slot wrap, the new snapshot is used from the next lit cycle.
- Asserting rst_n low mid-slot blanks the outputs immediately (asynchronously) and restarts the scan at digit 0.

## Configuration
- SEVEN_SEG_SCAN_LZB_EN defined: leading-zero blanking is active.
  - thos is blanked when it is 0.
  - huns is blanked when thos and huns are both 0.
  - tens is blanked when thos, huns and tens are all 0.
  - ones is never blanked.
  - A blanked digit keeps an all-ones for its slot, and its dp is also suppressed.
- Not defined: every digit is always shown, including leading zeros.

## Structure
- Package seven_seg_pkg holds:
  - the NUM_DIGITS=4 constant;
  - the 7-bit active-low glyph constants for 0–9, SEG_DASH and SEG_OFF;
  - the digit-index typedef (2 bits).
- Sub-module bcd_to_seg is a combinational decoder: 4-bit BCD in, 7-bit active-low segments out, dash for codes above 9. Instantiate it once, on the muxed snapshot digit.

## Test plan
All scenarios use SCAN_DIV=8, GUARD=2, BLINK_FRAMES=2.
- Reset: hold rst_n=0 → an=4'hF, seg=7'h7F, dp=1. Release → first lit cycle at cycle 3, an=4'b1110.
- Load 1,2,3,4 (thos..ones) → over one frame, slots show ones=4 (seg=7'b0011001), then 3, 2, 1. Each lit slot lasts 6 cycles, and 2 guard cycles separate slots.
- Invalid code: load ones=4'hC → slot 0 shows seg=7'b0111111.
- Blink: blink_mask=4'b0001 → digit 0 is lit in frames 0–1, dark in frames 2–3, and lit again in frame 4. Other digits are unaffected.
- dp_en=1 with DP_DIGIT=2 → dp=0 only during the lit cycles of slot 2.
- LZB with macro defined: load 0,0,7,5 → slots 3 and 2 keep an=4'hF; slots 1 and 0 show 7 and 5. Without the macro, both zeros are shown.
